// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states, register index and bubble counter.
package hazard_pkg;

   typedef enum logic [1:0] {
      RESET_FLUSH = 2'd0,
      RUN         = 2'd1,
      REDIRECT    = 2'd2
   } hz_state_t;

   typedef logic [3:0] reg_idx_t;
   typedef logic [2:0] bub_cnt_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones; value visible the cycle after the enabling event.
// Synchronous clear wins over enable; no backpressure.
module sat_counter32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   output logic [31:0] count
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are combinational from state and inputs (zero latency).
// Priority: dmem wait freezes everything, then redirect, load-use stall, and fetch wait.
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int unsigned REDIRECT_CYCLES = 1,
   parameter int unsigned RESET_BUBBLES   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  rs1_ID,
   input  logic [3:0]  rs2_ID,
   input  logic        uses_rs1_ID,
   input  logic        uses_rs2_ID,
   input  logic [3:0]  rd_EX,
   input  logic        mem_read_EX,
   input  logic        branch_taken_EX,
   input  logic        imem_ready,
   input  logic        dmem_busy_MEM,
   output logic        stall_PC,
   output logic        stall,
   output logic        invalid_IF,
   output logic        bubble_EX,
   output logic        freeze_EX_MEM,
   output logic        redirect,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   localparam bub_cnt_t RST_LOAD = bub_cnt_t'(RESET_BUBBLES);
   localparam bub_cnt_t RDR_LOAD = bub_cnt_t'(REDIRECT_CYCLES - 1);

   hz_state_t state_q, state_d;
   bub_cnt_t  cnt_q, cnt_d;
   reg_idx_t  rs1, rs2, rd;
   logic      load_use;

   assign rs1 = reg_idx_t'(rs1_ID);
   assign rs2 = reg_idx_t'(rs2_ID);
   assign rd  = reg_idx_t'(rd_EX);

   // x0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign load_use = mem_read_EX && (rd != 4'd0) &&
                     ((uses_rs1_ID && (rs1 == rd)) || (uses_rs2_ID && (rs2 == rd)));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      stall_PC      = 1'b0;
      stall         = 1'b0;
      invalid_IF    = 1'b0;
      bubble_EX     = 1'b0;
      freeze_EX_MEM = 1'b0;
      redirect      = 1'b0;

      case (state_q)
         RESET_FLUSH: begin
            if (cnt_q != 3'd0) begin
               invalid_IF = 1'b1;
               stall_PC   = 1'b1;
               cnt_d      = cnt_q - 3'd1;
            end
            if (cnt_q <= 3'd1) begin
               state_d = RUN;
            end
         end

         default: begin
            if (dmem_busy_MEM) begin
               freeze_EX_MEM = 1'b1;
               stall         = 1'b1;
               stall_PC      = 1'b1;
            end else if (branch_taken_EX) begin
               // ID instruction is squashed, so a coincident load-use is moot.
               redirect   = 1'b1;
               invalid_IF = 1'b1;
               bubble_EX  = 1'b1;
               cnt_d      = RDR_LOAD;
               state_d    = (RDR_LOAD != 3'd0) ? REDIRECT : RUN;
            end else if (load_use) begin
               stall     = 1'b1;
               stall_PC  = 1'b1;
               bubble_EX = 1'b1;
            end else if (state_q == REDIRECT) begin
               invalid_IF = (cnt_q != 3'd0);
               stall_PC   = !imem_ready;
               if (cnt_q != 3'd0) begin
                  cnt_d = cnt_q - 3'd1;
               end
               if (cnt_q <= 3'd1) begin
                  state_d = RUN;
               end
            end else if (!imem_ready) begin
               stall_PC   = 1'b1;
               invalid_IF = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RESET_FLUSH;
         cnt_q   <= RST_LOAD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   sat_counter32 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .en    (stall),
      .count (stall_count)
   );

   sat_counter32 u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .en    (redirect),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller with REDIRECT_CYCLES=2, RESET_BUBBLES=2.
module tb_pipeline_hazard_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rs1_ID, rs2_ID, rd_EX;
   logic        uses_rs1_ID, uses_rs2_ID, mem_read_EX, branch_taken_EX;
   logic        imem_ready, dmem_busy_MEM;
   logic        stall_PC, stall, invalid_IF, bubble_EX, freeze_EX_MEM, redirect;
   logic [31:0] stall_count, flush_count;
   logic [5:0]  ctl;

   int n_chk = 0;
   int n_bad = 0;

   // {stall_PC, stall, invalid_IF, bubble_EX, freeze_EX_MEM, redirect}
   localparam logic [5:0] C_IDLE  = 6'b000000;
   localparam logic [5:0] C_FLUSH = 6'b101000;
   localparam logic [5:0] C_LU    = 6'b110100;
   localparam logic [5:0] C_BR    = 6'b001101;
   localparam logic [5:0] C_FRZ   = 6'b110010;
   localparam logic [5:0] C_BUB   = 6'b001000;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(
      .REDIRECT_CYCLES (2),
      .RESET_BUBBLES   (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rs1_ID          (rs1_ID),
      .rs2_ID          (rs2_ID),
      .uses_rs1_ID     (uses_rs1_ID),
      .uses_rs2_ID     (uses_rs2_ID),
      .rd_EX           (rd_EX),
      .mem_read_EX     (mem_read_EX),
      .branch_taken_EX (branch_taken_EX),
      .imem_ready      (imem_ready),
      .dmem_busy_MEM   (dmem_busy_MEM),
      .stall_PC        (stall_PC),
      .stall           (stall),
      .invalid_IF      (invalid_IF),
      .bubble_EX       (bubble_EX),
      .freeze_EX_MEM   (freeze_EX_MEM),
      .redirect        (redirect),
      .stall_count     (stall_count),
      .flush_count     (flush_count)
   );

   assign ctl = {stall_PC, stall, invalid_IF, bubble_EX, freeze_EX_MEM, redirect};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      rs1_ID = 4'd0; rs2_ID = 4'd0; rd_EX = 4'd0;
      uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0;
      mem_read_EX = 1'b0; branch_taken_EX = 1'b0;
      imem_ready = 1'b1; dmem_busy_MEM = 1'b0;
   endtask

   // Advance to the next falling edge, leaving inputs for the caller to set.
   task automatic next_cyc();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (3) next_cyc();
      #1;
      chk("rst_ctl", 32'(ctl), 32'(C_FLUSH));
      chk("rst_stall_cnt", stall_count, 32'd0);
      chk("rst_flush_cnt", flush_count, 32'd0);

      rst = 1'b0;
      #1 chk("rb_cycle1", 32'(ctl), 32'(C_FLUSH));
      next_cyc(); #1 chk("rb_cycle2", 32'(ctl), 32'(C_FLUSH));
      next_cyc(); #1 chk("rb_done", 32'(ctl), 32'(C_IDLE));

      // load-use on rs2
      next_cyc();
      mem_read_EX = 1'b1; rd_EX = 4'd5; rs2_ID = 4'd5; uses_rs2_ID = 1'b1;
      #1 chk("lu_ctl", 32'(ctl), 32'(C_LU));
      chk("lu_cnt_before", stall_count, 32'd0);
      next_cyc();
      idle_inputs();
      #1 chk("lu_after_ctl", 32'(ctl), 32'(C_IDLE));
      chk("lu_stall_cnt", stall_count, 32'd1);

      // load to x0 and unused-operand match must not stall
      next_cyc();
      mem_read_EX = 1'b1; rd_EX = 4'd0; rs2_ID = 4'd0; uses_rs2_ID = 1'b1;
      #1 chk("x0_no_stall", 32'(ctl), 32'(C_IDLE));
      rd_EX = 4'd7; rs1_ID = 4'd7; uses_rs1_ID = 1'b0; rs2_ID = 4'd2;
      #1 chk("unused_rs1_no_stall", 32'(ctl), 32'(C_IDLE));
      next_cyc();
      idle_inputs();
      #1 chk("x0_stall_cnt", stall_count, 32'd1);

      // taken branch with coincident load-use
      mem_read_EX = 1'b1; rd_EX = 4'd3; rs1_ID = 4'd3; uses_rs1_ID = 1'b1;
      branch_taken_EX = 1'b1;
      #1 chk("br_ctl", 32'(ctl), 32'(C_BR));
      next_cyc();
      idle_inputs();
      dmem_busy_MEM = 1'b1;
      #1 chk("br_flush_cnt", flush_count, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("frz_ctl%0d", i), 32'(ctl), 32'(C_FRZ));
         next_cyc();
         #1;
      end
      dmem_busy_MEM = 1'b0;
      #1 chk("frz_stall_cnt", stall_count, 32'd4);
      chk("redir_resume", 32'(ctl), 32'(C_BUB));
      next_cyc(); #1 chk("redir_done", 32'(ctl), 32'(C_IDLE));
      chk("redir_flush_cnt", flush_count, 32'd1);

      // fetch wait
      imem_ready = 1'b0;
      #1 chk("imem_wait1", 32'(ctl), 32'(C_FLUSH));
      next_cyc(); #1 chk("imem_wait2", 32'(ctl), 32'(C_FLUSH));
      next_cyc();
      imem_ready = 1'b1;
      #1 chk("imem_back", 32'(ctl), 32'(C_IDLE));
      chk("imem_stall_cnt", stall_count, 32'd4);

      // saturation of stall_count
      force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
      #1 release dut.u_stall_cnt.cnt_q;
      dmem_busy_MEM = 1'b1;
      next_cyc(); #1 chk("sat_reach", stall_count, 32'hFFFF_FFFF);
      next_cyc(); next_cyc();
      #1 chk("sat_hold", stall_count, 32'hFFFF_FFFF);
      dmem_busy_MEM = 1'b0;

      // reset in the middle of a redirect
      branch_taken_EX = 1'b1;
      next_cyc();
      branch_taken_EX = 1'b0;
      #1 chk("pre_rst_redir", 32'(ctl), 32'(C_BUB));
      chk("pre_rst_flush_cnt", flush_count, 32'd2);
      #2 rst = 1'b1;
      #1 chk("mid_rst_ctl", 32'(ctl), 32'(C_FLUSH));
      chk("mid_rst_stall_cnt", stall_count, 32'd0);
      chk("mid_rst_flush_cnt", flush_count, 32'd0);
      next_cyc();
      rst = 1'b0;
      #1 chk("post_rst_ctl", 32'(ctl), 32'(C_FLUSH));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32E pipeline (IF, ID, EX, MEM, WB).
- Drives the stall and invalid (bubble) controls of the IF/ID register, plus bubble/freeze controls for ID/EX, EX/MEM and the PC.
- Resolves load-use hazards, taken-branch/jump redirects, instruction-fetch wait and data-memory wait with a fixed priority.
- Keeps saturating stall/flush performance counters.

Parameters:
- REDIRECT_CYCLES, 1, cycles IF output is marked invalid after a redirect (1..7).
- RESET_BUBBLES, 2, cycles after reset release during which IF is forced invalid (0..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_ID  in  4  ID source register 1 (x0-x15).
- rs2_ID  in  4  ID source register 2.
- uses_rs1_ID  in  1  ID instruction reads rs1.
- uses_rs2_ID  in  1  ID instruction reads rs2.
- rd_EX  in  4  EX destination register.
- mem_read_EX  in  1  EX instruction is a load.
- branch_taken_EX  in  1  EX resolved a taken branch or jump.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_busy_MEM  in  1  MEM access not complete.
- stall_PC  out  1  hold PC.
- stall  out  1  hold IF/ID (to IF/ID stall).
- invalid_IF  out  1  IF output is a bubble (to IF/ID invalid_IF).
- bubble_EX  out  1  load NOP into ID/EX.
- freeze_EX_MEM  out  1  hold ID/EX, EX/MEM and MEM/WB.
- redirect  out  1  PC takes the branch target this cycle.
- stall_count  out  32  saturating count of cycles with stall=1.
- flush_count  out  32  saturating count of redirects.

Behaviour:
- Outputs are combinational from state plus inputs. Counters and state are registered.
- Reset values: state=RESET_FLUSH, bubble counter=RESET_BUBBLES, both counters 0, combinational outputs follow state. Asserting rst mid-operation returns to this immediately, with no completion of pending actions.
- Hazard conditions:
  - load_use = mem_read_EX & rd_EX!=0 & ((uses_rs1_ID & rs1_ID==rd_EX) | (uses_rs2_ID & rs2_ID==rd_EX)).
  - x0 never hazards.
- States:
  - RESET_FLUSH: invalid_IF=1, stall_PC=1. Decrement the counter each cycle; go to RUN when it reaches 0. RESET_BUBBLES=0 enters RUN on the first cycle after reset.
  - RUN: the priority rules below apply.
  - REDIRECT: invalid_IF=1 while the counter is >0. Decrement each cycle, then return to RUN. dmem_busy_MEM still freezes and pauses the counter. A new branch_taken_EX restarts the counter with a new redirect.
- Priority in RUN and REDIRECT, highest first:
  1. dmem_busy_MEM: freeze_EX_MEM=1, stall=1, stall_PC=1, invalid_IF=0, bubble_EX=0, redirect=0. Hold all state and counters, except that stall_count increments.
  2. branch_taken_EX: redirect=1, invalid_IF=1, bubble_EX=1, stall=0, stall_PC=0. Any simultaneous load_use is ignored because the ID instruction is squashed. Go to REDIRECT with counter=REDIRECT_CYCLES-1. flush_count increments.
  3. load_use: stall=1, stall_PC=1, bubble_EX=1. Lasts exactly one cycle, because next cycle the load is in MEM and rd_EX no longer matches.
  4. !imem_ready: stall_PC=1, invalid_IF=1, stall=0.
  5. Otherwise all outputs are 0.
- stall=1 together with invalid_IF=1 never occurs.
- stall_count increments on every cycle with stall=1. Both counters saturate at 32'hFFFFFFFF without wrapping.
- Latency: all controls take effect on the same cycle's rising edge. No added pipeline delay.

Decomposition:
- Shared package hazard_pkg holds:
  - state typedef enum {RESET_FLUSH, RUN, REDIRECT}.
  - localparam NOP_INSTR=32'h13.
  - 4-bit reg_idx_t typedef.
- One natural sub-module, sat_counter32: enable and clear inputs, saturating. Instantiated twice.

Test Plan:
- Reset with RESET_BUBBLES=2, imem_ready=1: invalid_IF=1 and stall_PC=1 for 2 cycles after rst falls, then all outputs 0.
- Load-use: mem_read_EX=1, rd_EX=5, rs2_ID=5, uses_rs2_ID=1 -> stall=1, bubble_EX=1 for 1 cycle, stall_count=1. Repeat with rd_EX=0 -> no stall.
- Branch taken with simultaneous load-use (rd_EX=3, rs1_ID=3) and REDIRECT_CYCLES=2 -> redirect=1, bubble_EX=1, stall=0, then invalid_IF=1 for 1 more cycle; flush_count=1.
- dmem_busy_MEM=1 for 3 cycles during REDIRECT -> freeze_EX_MEM=1 for 3 cycles, redirect counter paused, stall_count+=3, and invalid_IF resumes afterwards.
- imem_ready=0 for 2 cycles in RUN -> invalid_IF=1, stall_PC=1, stall=0.
- Preload stall_count to FFFFFFFE via force, then 3 stall cycles -> stall_count=FFFFFFFF. Asserting rst mid-REDIRECT -> counters 0, state RESET_FLUSH.
